// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Package    : usr_pkg
// Description: Mode codes and FSM state encoding for univ_shift_reg.
// Revision   : 1.0 - initial release
// ============================================================================
package usr_pkg;

   typedef enum logic [2:0] {
      USR_HOLD  = 3'd0,
      USR_LOAD  = 3'd1,
      USR_CLEAR = 3'd2,
      USR_SHL   = 3'd3,
      USR_SHR   = 3'd4,
      USR_ASR   = 3'd5,
      USR_ROL   = 3'd6,
      USR_ROR   = 3'd7
   } usr_mode_e;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } usr_state_e;

   // Codes 3..7 all move bits and run as counted bursts.
   function automatic logic is_shift(input usr_mode_e m);
      return (m >= USR_SHL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/usr_next_val.sv
`default_nettype none
// ============================================================================
// Module     : usr_next_val
// Description: Combinational mode mux producing the next register word and
//              the bit that leaves it on a shift.
// Revision   : 1.0 - initial release
// ============================================================================
module usr_next_val
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  usr_mode_e        mode,
   output logic [WIDTH-1:0] q_next,
   output logic             sout_next
);

   always_comb begin
      q_next    = q;
      sout_next = 1'b0;
      case (mode)
         USR_HOLD:  q_next = q;
         USR_LOAD:  q_next = d;
         USR_CLEAR: q_next = '0;
         USR_SHL: begin
            q_next    = {q[WIDTH-2:0], sin};
            sout_next = q[WIDTH-1];
         end
         USR_SHR: begin
            q_next    = {sin, q[WIDTH-1:1]};
            sout_next = q[0];
         end
         USR_ASR: begin
            q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         USR_ROL: begin
            q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
            sout_next = q[WIDTH-1];
         end
         USR_ROR: begin
            q_next    = {q[0], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         default: begin
            q_next    = q;
            sout_next = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module     : univ_shift_reg
// Description: Universal shift register with counted shift bursts and
//              busy/done handshake. Define USR_PARITY_EN to add a registered
//              parity output.
// Revision   : 1.0 - initial release
// ============================================================================
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] len,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_not,
   output logic             sout,
   output logic             busy,
   output logic             done
`ifdef USR_PARITY_EN
   ,
   output logic             parity
`endif
);

   usr_state_e       r_state, w_state_d;
   usr_mode_e        r_mode,  w_mode_d;
   usr_mode_e        w_op_mode;
   logic [CNT_W-1:0] r_cnt,   w_cnt_d;
   logic [WIDTH-1:0] r_q,     w_q_d;
   logic [WIDTH-1:0] w_mux_q;
   logic             r_sout,  w_sout_d;
   logic             w_mux_sout;
   logic             r_done,  w_done_d;

   // During a burst the latched mode drives the mux; otherwise the live input.
   assign w_op_mode = (r_state == BURST) ? r_mode : usr_mode_e'(mode);

   usr_next_val #(
      .WIDTH (WIDTH)
   ) u_next_val (
      .q         (r_q),
      .d         (d),
      .sin       (sin),
      .mode      (w_op_mode),
      .q_next    (w_mux_q),
      .sout_next (w_mux_sout)
   );

   always_comb begin
      w_q_d     = r_q;
      w_sout_d  = r_sout;
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_mode_d  = r_mode;
      w_done_d  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (!is_shift(w_op_mode)) begin
                  w_q_d    = w_mux_q;
                  w_done_d = 1'b1;
               end else if (len == '0) begin
                  w_done_d = 1'b1;
               end else begin
                  w_q_d    = w_mux_q;
                  w_sout_d = w_mux_sout;
                  w_cnt_d  = len - CNT_W'(1);
                  w_mode_d = w_op_mode;
                  if (len == CNT_W'(1)) w_done_d  = 1'b1;
                  else                  w_state_d = BURST;
               end
            end
         end
         BURST: begin
            w_q_d    = w_mux_q;
            w_sout_d = w_mux_sout;
            w_cnt_d  = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_done_d  = 1'b1;
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_mode  <= USR_HOLD;
         r_cnt   <= '0;
         r_q     <= RESET_VALUE;
         r_sout  <= 1'b0;
         r_done  <= 1'b0;
      end else if (en) begin
         r_state <= w_state_d;
         r_mode  <= w_mode_d;
         r_cnt   <= w_cnt_d;
         r_q     <= w_q_d;
         r_sout  <= w_sout_d;
         r_done  <= w_done_d;
      end
   end

`ifdef USR_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   r_parity <= ^RESET_VALUE;
      else if (en) r_parity <= ^w_q_d;
   end

   assign parity = r_parity;
`endif

   assign q     = r_q;
   assign q_not = ~r_q;
   assign sout  = r_sout;
   assign busy  = (r_state == BURST);
   assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module     : tb_univ_shift_reg
// Description: Directed self-checking bench for univ_shift_reg; completed
//              commands are checked against a queue of expected results.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

   localparam logic [7:0] RV = 8'h3C;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic       sout;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, en, start, sin;
   logic [2:0] mode;
   logic [3:0] len;
   logic [7:0] d;
   logic [7:0] q, q_not;
   logic       sout, busy, done;
`ifdef USR_PARITY_EN
   logic       parity;
`endif

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n;

   univ_shift_reg #(
      .WIDTH       (8),
      .RESET_VALUE (RV),
      .CNT_W       (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .start  (start),
      .mode   (mode),
      .len    (len),
      .d      (d),
      .sin    (sin),
      .q      (q),
      .q_not  (q_not),
      .sout   (sout),
      .busy   (busy),
      .done   (done)
`ifdef USR_PARITY_EN
      ,
      .parity (parity)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after acceptance.
   task automatic cmd(input logic [2:0] m, input logic [3:0] l,
                      input logic [7:0] dv, input logic s);
      mode  = m;
      len   = l;
      d     = dv;
      sin   = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      exp_t e;
      cyc = 0;
      while (done !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, "_q"},    {24'd0, q},    {24'd0, e.q});
         chk({e.tag, "_sout"}, {31'd0, sout}, {31'd0, e.sout});
      end
   endtask

   function automatic exp_t ror_model(input string tag, input logic [7:0] v,
                                      input int k, input logic s0);
      exp_t r;
      r.tag  = tag;
      r.sout = s0;
      for (int i = 0; i < k; i++) begin
         r.sout = v[0];
         v      = {v[0], v[7:1]};
      end
      r.q = v;
      return r;
   endfunction

   initial begin
      reset = 1'b1; en = 1'b1; start = 1'b0;
      mode = 3'd0; len = 4'd0; d = 8'd0; sin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_q",    {24'd0, q},     {24'd0, RV});
      chk("rst_qn",   {24'd0, q_not}, {24'd0, ~RV});
      chk("rst_sout", {31'd0, sout},  32'd0);
      chk("rst_busy", {31'd0, busy},  32'd0);
      chk("rst_done", {31'd0, done},  32'd0);
`ifdef USR_PARITY_EN
      chk("rst_par",  {31'd0, parity}, {31'd0, ^RV});
`endif
      reset = 1'b0;
      @(negedge clk);

      sb.push_back('{"load_a5", 8'hA5, 1'b0});
      cmd(3'd1, 4'd0, 8'hA5, 1'b0);
      chk("load_qn",   {24'd0, q_not}, 32'h5A);
      chk("load_done", {31'd0, done},  32'd1);
      wait_done(4, n);

      sb.push_back('{"rol3", 8'h2D, 1'b1});
      cmd(3'd6, 4'd3, 8'h00, 1'b0);
      chk("rol_busy",  {31'd0, busy}, 32'd1);
      chk("rol_ndone", {31'd0, done}, 32'd0);
      wait_done(8, n);
      chk("rol_busy_cyc", n, 32'd2);
      chk("rol_busy_end", {31'd0, busy}, 32'd0);

      sb.push_back('{"load_81", 8'h81, 1'b1});
      cmd(3'd1, 4'd0, 8'h81, 1'b0);
      wait_done(4, n);
      sb.push_back('{"asr2", 8'hE0, 1'b0});
      cmd(3'd5, 4'd2, 8'h00, 1'b0);
      wait_done(8, n);
      chk("asr_lat", n, 32'd1);

      sb.push_back('{"load_01", 8'h01, 1'b0});
      cmd(3'd1, 4'd0, 8'h01, 1'b0);
      wait_done(4, n);
      sb.push_back('{"shr1", 8'h80, 1'b1});
      cmd(3'd4, 4'd1, 8'h00, 1'b1);
      chk("shr_busy", {31'd0, busy}, 32'd0);
      chk("shr_done", {31'd0, done}, 32'd1);
      wait_done(4, n);

      sb.push_back('{"shl0", 8'h80, 1'b1});
      cmd(3'd3, 4'd0, 8'h00, 1'b1);
      chk("len0_busy", {31'd0, busy}, 32'd0);
      chk("len0_done", {31'd0, done}, 32'd1);
      wait_done(4, n);

      sb.push_back('{"rol4_ign", 8'h08, 1'b0});
      cmd(3'd6, 4'd4, 8'h00, 1'b0);
      mode = 3'd1; d = 8'hFF; len = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", {31'd0, busy}, 32'd1);
      wait_done(8, n);
      chk("ign_lat", n, 32'd2);

      sb.push_back(ror_model("ror4_stall", 8'h08, 4, 1'b0));
      cmd(3'd7, 4'd4, 8'h00, 1'b0);
      en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_q",    {24'd0, q},    {24'd0, ror_model("m", 8'h08, 1, 1'b0).q});
         chk("stall_busy", {31'd0, busy}, 32'd1);
      end
      en = 1'b1;
      wait_done(12, n);
      chk("ror_total", 4 + n, 32'd7);

      en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("done_hold", {31'd0, done}, 32'd1);
      end
      en = 1'b1;
      @(negedge clk);
      chk("done_drop", {31'd0, done}, 32'd0);

      cmd(3'd3, 4'd5, 8'h00, 1'b1);
      @(negedge clk);
      chk("mid_busy_pre", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_q",    {24'd0, q},    {24'd0, RV});
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_sout", {31'd0, sout}, 32'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_q",    {24'd0, q},    {24'd0, RV});

`ifdef USR_PARITY_EN
      sb.push_back('{"par_load", 8'h07, 1'b0});
      cmd(3'd1, 4'd0, 8'h07, 1'b0);
      chk("par_07", {31'd0, parity}, 32'd1);
      wait_done(4, n);
      sb.push_back('{"par_shl", 8'h0F, 1'b0});
      cmd(3'd3, 4'd1, 8'h00, 1'b1);
      chk("par_0f", {31'd0, parity}, 32'd0);
      wait_done(4, n);
`endif

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
